// File: rtl/img_window_streamer.sv
// Image buffer and sliding-window source.
// Loads an IMG_DIM x IMG_DIM image a few pixels per beat into a register file, then streams
// every valid KxK neighbourhood (K = 3 or 5) in raster order over a valid/ready handshake.
module img_window_streamer #(
  parameter int unsigned IMG_DIM     = 20,
  parameter int unsigned BIT_LENGTH  = 5,
  parameter int unsigned PIX_PER_CYC = 3,
  parameter int unsigned MAX_K       = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_valid,
  input  logic [PIX_PER_CYC*BIT_LENGTH-1:0]   pixel_in,
  input  logic                                load_end,
  input  logic                                ksize,
  output logic                                load_ready,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic [MAX_K*MAX_K*BIT_LENGTH-1:0]   win_data,
  output logic [$clog2(IMG_DIM)-1:0]          win_row,
  output logic [$clog2(IMG_DIM)-1:0]          win_col,
  output logic                                win_last,
  output logic                                done
);

  localparam int unsigned NPIX  = IMG_DIM * IMG_DIM;
  // Headroom so index + k never wraps before the bounds test.
  localparam int unsigned IDX_W = $clog2(NPIX + PIX_PER_CYC + 1);
  localparam int unsigned POS_W = $clog2(IMG_DIM);
  localparam int unsigned WIN_W = MAX_K * MAX_K * BIT_LENGTH;

  typedef enum logic [1:0] {
    StLoad,
    StScan,
    StDone
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       load_idx_q;
  logic                   ksize_q;
  logic [BIT_LENGTH-1:0]  img_q [NPIX];

  logic                   load_fire;
  logic [IDX_W-1:0]       idx_sum;
  logic [IDX_W-1:0]       nxt_idx;
  logic [POS_W-1:0]       last_pos;
  int unsigned            k_cur;
  logic [POS_W-1:0]       nxt_row;
  logic [POS_W-1:0]       nxt_col;
  logic                   nxt_last;
  logic [WIN_W-1:0]       nxt_data;
  int unsigned            addr;

  // load_ready is high exactly while in StLoad, so it doubles as the state qualifier.
  assign load_fire = load_valid & load_ready;

  // Write index advances by one beat and parks at NPIX once the image is full.
  assign idx_sum = load_idx_q + IDX_W'(PIX_PER_CYC);
  assign nxt_idx = (idx_sum >= IDX_W'(NPIX)) ? IDX_W'(NPIX) : idx_sum;

  assign k_cur    = ksize_q ? 32'd5 : 32'd3;
  assign last_pos = ksize_q ? POS_W'(IMG_DIM - 5) : POS_W'(IMG_DIM - 3);

  // Position of the window to present next: (0,0) when nothing is held, else raster successor.
  always_comb begin
    nxt_row = '0;
    nxt_col = '0;
    if (win_valid) begin
      if (win_col == last_pos) begin
        nxt_row = win_row + 1'b1;
      end else begin
        nxt_row = win_row;
        nxt_col = win_col + 1'b1;
      end
    end
  end

  assign nxt_last = (nxt_row == last_pos) && (nxt_col == last_pos);

  // Gather the KxK neighbourhood at the next position; slots outside K stay zero.
  always_comb begin
    nxt_data = '0;
    addr     = 0;
    for (int unsigned i = 0; i < MAX_K; i++) begin
      for (int unsigned j = 0; j < MAX_K; j++) begin
        addr = (32'(nxt_row) + i) * IMG_DIM + 32'(nxt_col) + j;
        if (i < k_cur && j < k_cur && addr < NPIX) begin
          nxt_data[(i*MAX_K+j)*BIT_LENGTH +: BIT_LENGTH] = img_q[IDX_W'(addr)];
        end
      end
    end
  end

  // Image register file: accepted beats write their in-range pixels, the rest are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < NPIX; n++) begin
        img_q[n] <= '0;
      end
    end else if (load_fire) begin
      for (int unsigned k = 0; k < PIX_PER_CYC; k++) begin
        if (32'(load_idx_q) + k < NPIX) begin
          img_q[IDX_W'(32'(load_idx_q) + k)] <= pixel_in[k*BIT_LENGTH +: BIT_LENGTH];
        end
      end
    end
  end

  // Frame control FSM with registered handshake and window outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLoad;
      load_idx_q <= '0;
      ksize_q    <= 1'b0;
      load_ready <= 1'b1;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (load_fire) begin
            load_idx_q <= nxt_idx;
            if (load_end) begin
              ksize_q    <= ksize;
              load_ready <= 1'b0;
              state_q    <= StScan;
            end
          end
        end
        StScan: begin
          // Output register advances only when empty or when the held window is taken.
          if (!win_valid || win_ready) begin
            if (win_valid && win_last) begin
              win_valid <= 1'b0;
              win_last  <= 1'b0;
              done      <= 1'b1;
              state_q   <= StDone;
            end else begin
              win_valid <= 1'b1;
              win_data  <= nxt_data;
              win_row   <= nxt_row;
              win_col   <= nxt_col;
              win_last  <= nxt_last;
            end
          end
        end
        StDone: begin
          load_idx_q <= '0;
          load_ready <= 1'b1;
          state_q    <= StLoad;
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_window_streamer.sv
// Bench for img_window_streamer: image/window model built from the frame rules, with one
// per-cycle compare process against a queue of expected windows.
module tb_img_window_streamer;

  localparam int IMG_DIM = 20;
  localparam int BL      = 5;
  localparam int P       = 3;
  localparam int MAX_K   = 5;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int PW      = $clog2(IMG_DIM);
  localparam int WW      = MAX_K * MAX_K * BL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [P*BL-1:0] pixel_in = '0;
  logic          load_end = 1'b0;
  logic          ksize = 1'b0;
  logic          load_ready;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [WW-1:0] win_data;
  logic [PW-1:0] win_row;
  logic [PW-1:0] win_col;
  logic          win_last;
  logic          done;

  img_window_streamer #(
    .IMG_DIM    (IMG_DIM),
    .BIT_LENGTH (BL),
    .PIX_PER_CYC(P),
    .MAX_K      (MAX_K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .pixel_in  (pixel_in),
    .load_end  (load_end),
    .ksize     (ksize),
    .load_ready(load_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            row;
    int            col;
    logic [WW-1:0] data;
    bit            last;
  } win_t;

  win_t          exp_q[$];
  logic [BL-1:0] model_img [NPIX];
  int            checks = 0;
  int            passes = 0;
  int            popped = 0;
  bit            exp_done = 1'b0;
  bit            rnd_ready = 1'b0;

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic chk_vec(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Every KxK window of the model image, raster order, unused slots zero.
  task automatic build_windows(input bit ks);
    int k;
    int n;
    win_t w;
    k = ks ? 5 : 3;
    n = IMG_DIM - k + 1;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        w.row  = r;
        w.col  = c;
        w.last = (r == n - 1) && (c == n - 1);
        w.data = '0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            w.data[(i*MAX_K+j)*BL +: BL] = model_img[(r+i)*IMG_DIM + c + j];
        exp_q.push_back(w);
      end
    end
  endtask

  // Hand-derived values for the ramp image that pin the model.
  task automatic pin_model(input int which);
    int lit3 [9];
    logic [WW-1:0] d;
    lit3 = '{0, 1, 2, 20, 21, 22, 8, 9, 10};
    if (which == 1) begin
      chk_int("pin3_count", exp_q.size(), 324);
      d = exp_q[0].data;
      for (int s = 0; s < 9; s++)
        chk_int($sformatf("pin3_slot%0d", s), int'(d[((s/3)*MAX_K + s%3)*BL +: BL]), lit3[s]);
      chk_int("pin3_last_row", exp_q[323].row, 17);
      chk_int("pin3_last_col", exp_q[323].col, 17);
      chk_int("pin3_last_flag", int'(exp_q[323].last), 1);
      chk_int("pin3_prev_flag", int'(exp_q[322].last), 0);
    end else if (which == 2) begin
      chk_int("pin5_count", exp_q.size(), 256);
      d = exp_q[0].data;
      chk_int("pin5_slot24", int'(d[24*BL +: BL]), 20);
      chk_int("pin5_last_row", exp_q[255].row, 15);
      chk_int("pin5_last_flag", int'(exp_q[255].last), 1);
    end
  endtask

  // Drives a frame of nbeats beats, load_end on the last; optional idle gaps with one stray load_end.
  task automatic load_frame(input int nbeats, input bit ks, input bit ramp, input bit gapped,
                            input int pin);
    logic [P*BL-1:0] pix;
    int spur;
    spur = gapped ? nbeats / 2 : -1;
    @(posedge clk);
    #1;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < P; k++)
        pix[k*BL +: BL] = ramp ? BL'((b * P + k) % 32) : BL'($urandom);
      load_valid = 1'b1;
      pixel_in   = pix;
      load_end   = (b == nbeats - 1);
      ksize      = (b == nbeats - 1) ? ks : 1'($urandom);
      @(negedge clk);
      chk_int("load_ready", int'(load_ready), 1);
      @(posedge clk);
      for (int k = 0; k < P; k++)
        if (b * P + k < NPIX) model_img[b*P+k] = pix[k*BL +: BL];
      if (b == nbeats - 1) begin
        build_windows(ks);
        pin_model(pin);
      end
      #1;
      load_valid = 1'b0;
      load_end   = 1'b0;
      ksize      = 1'($urandom);
      if (gapped && b < nbeats - 1) begin
        pixel_in = (P*BL)'($urandom);
        load_end = (b == spur);
        @(posedge clk);
        #1;
        load_end = 1'b0;
      end
    end
    @(negedge clk);
    chk_int("valid_wait", int'(win_valid), 0);
    @(negedge clk);
    chk_int("valid_rise", int'(win_valid), 1);
  endtask

  task automatic wait_frame();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    chk_int("frame_drain", exp_q.size(), 0);
    @(negedge clk);
    chk_int("done_load_ready", int'(load_ready), 0);
    @(negedge clk);
    chk_int("idle_load_ready", int'(load_ready), 1);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    win_ready = rnd_ready ? 1'($urandom) : 1'b1;
  end

  // Per-cycle compare: done pulse timing and every presented window against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      bit nxt_done;
      nxt_done = 1'b0;
      chk_int("done", int'(done), int'(exp_done));
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          chk_int("win_spurious", int'(win_valid), 0);
        end else begin
          chk_vec($sformatf("win(%0d,%0d).data", exp_q[0].row, exp_q[0].col), win_data,
                  exp_q[0].data);
          chk_int("win_row", int'(win_row), exp_q[0].row);
          chk_int("win_col", int'(win_col), exp_q[0].col);
          chk_int("win_last", int'(win_last), int'(exp_q[0].last));
          if (win_ready) begin
            nxt_done = exp_q[0].last;
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      exp_done = nxt_done;
    end
  end

  initial begin
    int cyc;
    for (int n = 0; n < NPIX; n++) model_img[n] = '0;
    #12;
    chk_int("rst_load_ready", int'(load_ready), 1);
    chk_int("rst_win_valid", int'(win_valid), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_win_last", int'(win_last), 0);
    chk_int("rst_win_pos", int'({win_row, win_col}), 0);
    chk_vec("rst_win_data", win_data, '0);
    @(negedge clk);
    reset = 1'b0;

    // 3x3 ramp, 2 pixels dropped
    load_frame(134, 1'b0, 1'b1, 1'b0, 1);
    wait_frame();
    // 5x5 on the same image
    load_frame(134, 1'b1, 1'b1, 1'b0, 2);
    wait_frame();
    // backpressure
    rnd_ready = 1'b1;
    load_frame(134, 1'b0, 1'b1, 1'b0, 1);
    wait_frame();
    // overflow then early end over random data
    load_frame(140, 1'b0, 1'b0, 1'b0, 0);
    wait_frame();
    load_frame(10, 1'b1, 1'b0, 1'b0, 0);
    wait_frame();
    // gapped load with a stray load_end
    load_frame(134, 1'b1, 1'b0, 1'b1, 0);
    wait_frame();

    // reset mid-scan
    rnd_ready = 1'b0;
    load_frame(134, 1'b0, 1'b1, 1'b0, 1);
    popped = 0;
    cyc = 0;
    while (popped < 50 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk_int("abort_reached", popped, 50);
    #1;
    reset = 1'b1;
    exp_q.delete();
    for (int n = 0; n < NPIX; n++) model_img[n] = '0;
    #1;
    chk_int("abort_win_valid", int'(win_valid), 0);
    chk_int("abort_load_ready", int'(load_ready), 1);
    @(negedge clk);
    chk_int("abort_next_valid", int'(win_valid), 0);
    chk_int("abort_next_ready", int'(load_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // one-beat frame exposes the cleared image everywhere else
    load_frame(1, 1'b0, 1'b1, 1'b0, 0);
    wait_frame();
    load_frame(134, 1'b0, 1'b1, 1'b0, 1);
    wait_frame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
